// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: shared FSM state encoding and bus-level constants for the I2C target.
package i2c_target_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP} state_t;
  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;
  localparam logic BUS_IDLE = 1'b1;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronizes SCL/SDA and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync
  import i2c_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [SYNC_STAGES-1:0] scl_sr, sda_sr;
  logic scl_s, scl_q, sda_q;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      scl_sr <= {SYNC_STAGES{BUS_IDLE}};
      sda_sr <= {SYNC_STAGES{BUS_IDLE}};
      scl_q  <= BUS_IDLE;
      sda_q  <= BUS_IDLE;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_i};
      sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_i};
      scl_q  <= scl_s;
      sda_q  <= sda;
    end
  assign scl_s    = scl_sr[SYNC_STAGES-1];
  assign sda      = sda_sr[SYNC_STAGES-1];
  assign scl_rise = scl_s && !scl_q;
  assign scl_fall = !scl_s && scl_q;
  assign start    = scl_s && scl_q && sda_q && !sda;
  assign stop     = scl_s && scl_q && !sda_q && sda;
endmodule

// File: rtl/i2c_target_core.sv
// i2c_target_core: I2C target FSM with byte-wide rx/tx handshakes on an open-drain bus.
// Define I2C_TARGET_STRETCH_EN to stretch SCL instead of flagging overrun/underrun.
module i2c_target_core
  import i2c_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       en_i,
  input  logic [6:0] own_addr_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       scl_dir_o,
  output logic       sda_dir_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       sel_o,
  output logic       rw_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       ovr_o,
  output logic       udr_o
);
  state_t state_q, state_d;
  logic sda, scl_rise, scl_fall, start, stop, ev_ok, tx_load, addr_hit, phase, ack;
  logic [2:0] cnt;
  logic [7:0] shreg;
`ifdef I2C_TARGET_STRETCH_EN
  logic stretch;
`endif
  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .scl_i(scl_i), .sda_i(sda_i), .sda(sda),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
  );
  assign scl_o    = 1'b0;
  assign sda_o    = 1'b0;
  assign ev_ok    = en_i && !start && !stop;
  assign addr_hit = shreg[6:0] == own_addr_i;
  // phase marks the second half of an ACK slot; the next falling edge hands over to the data byte
  assign tx_load  = ev_ok && scl_fall && phase && (state_q == TX_ACK || (state_q == ADDR_ACK && rw_o));
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (!en_i) state_d = IDLE;
    else if (start) state_d = ADDR;
    else if (stop) state_d = IDLE;
    else
      case (state_q)
        ADDR:     if (scl_rise && cnt == 3'd7) state_d = addr_hit ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (scl_fall && phase) state_d = rw_o ? TX : RX;
        RX:       if (scl_rise && cnt == 3'd7) state_d = RX_ACK;
        RX_ACK:   if (scl_fall && phase) state_d = RX;
        TX:       if (scl_fall && cnt == 3'd7) state_d = TX_ACK;
        TX_ACK:   state_d = (scl_rise && sda == SDA_NACK) ? WAIT_STOP : (scl_fall && phase) ? TX : TX_ACK;
        default:  ;
      endcase
  end
  always_comb begin
    sda_dir_o = en_i && ((state_q == ADDR_ACK && phase) || (state_q == RX_ACK && phase && ack) ||
                         (state_q == TX && !shreg[7]));
`ifdef I2C_TARGET_STRETCH_EN
    scl_dir_o = en_i && stretch;
`else
    scl_dir_o = 1'b0;
`endif
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      cnt        <= '0;
      shreg      <= '0;
      phase      <= 1'b0;
      ack        <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b0;
      sel_o      <= 1'b0;
      rw_o       <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      ovr_o      <= 1'b0;
      udr_o      <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
      stretch    <= 1'b0;
`endif
    end else begin
      start_o    <= en_i && start;
      stop_o     <= en_i && stop;
      tx_ready_o <= 1'b0;
      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
      if (!ev_ok) begin
        cnt   <= '0;
        phase <= 1'b0;
        sel_o <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
        stretch <= 1'b0;
`endif
        if (en_i && start) {ovr_o, udr_o} <= 2'b00;
      end else begin
        case (state_q)
          ADDR: if (scl_rise) begin
            shreg <= {shreg[6:0], sda};
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7 && addr_hit) {sel_o, rw_o} <= {1'b1, sda};
          end
          ADDR_ACK: if (scl_fall) phase <= !phase;
          RX: if (scl_rise) begin
            shreg <= {shreg[6:0], sda};
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              ack <= !rx_valid_o;
              if (!rx_valid_o) {rx_data_o, rx_valid_o} <= {shreg[6:0], sda, 1'b1};
`ifndef I2C_TARGET_STRETCH_EN
              if (rx_valid_o) ovr_o <= 1'b1;
`endif
            end
          end
          RX_ACK: begin
            if (scl_fall) phase <= !phase;
`ifdef I2C_TARGET_STRETCH_EN
            if (scl_fall && !phase && !ack) stretch <= 1'b1;
            if (stretch && !rx_valid_o) {rx_data_o, rx_valid_o, ack, stretch} <= {shreg, 3'b110};
`endif
          end
          TX: begin
            if (scl_fall) begin
              shreg <= {shreg[6:0], 1'b1};
              cnt   <= cnt + 3'd1;
            end
`ifdef I2C_TARGET_STRETCH_EN
            if (stretch && tx_valid_i) {shreg, tx_ready_o, stretch} <= {tx_data_i, 2'b10};
`endif
          end
          TX_ACK: if (scl_rise && sda == SDA_ACK) phase <= 1'b1;
                  else if (scl_fall && phase) phase <= 1'b0;
          default: ;
        endcase
        if (tx_load) begin
          cnt <= '0;
`ifdef I2C_TARGET_STRETCH_EN
          if (tx_valid_i) {shreg, tx_ready_o} <= {tx_data_i, 1'b1};
          else {shreg, stretch} <= {8'hFF, 1'b1};
`else
          shreg      <= tx_valid_i ? tx_data_i : 8'hFF;
          tx_ready_o <= tx_valid_i;
          udr_o      <= udr_o || !tx_valid_i;
`endif
        end
      end
    end
endmodule

// File: tb/tb_i2c_target_core.sv
// tb_i2c_target_core: bit-banged I2C master with an event scoreboard for the target core.
module tb_i2c_target_core;
  import i2c_target_pkg::*;
  localparam int T = 16;
  localparam int EV_START = 0, EV_STOP = 1, EV_RX = 2, EV_TX = 3;
  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
  logic rx_ready = 1'b1, tx_valid = 1'b0, dir_seen = 1'b0, rxv_prev = 1'b0;
  logic [6:0] own_addr = 7'h50;
  logic [7:0] tx_data = 8'h00, rx_data;
  logic scl_o, sda_o, scl_dir, sda_dir, rx_valid, tx_ready, sel, rw, start_p, stop_p, ovr, udr;
  logic scl_line, sda_line;
  ev_t exp_q[$];
  int checks = 0, errors = 0;

  assign scl_line = scl_m & ~scl_dir;
  assign sda_line = sda_m & ~sda_dir;

  i2c_target_core dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .own_addr_i(own_addr),
    .scl_i(scl_line), .sda_i(sda_line), .scl_o(scl_o), .sda_o(sda_o),
    .scl_dir_o(scl_dir), .sda_dir_o(sda_dir),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .sel_o(sel), .rw_o(rw), .start_o(start_p), .stop_o(stop_p), .ovr_o(ovr), .udr_o(udr)
  );

  initial forever #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push(int kind, logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  function automatic void chk_ev(int kind, logic [7:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d data %0h expected none", kind, data);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_data", data, e.data);
    end
  endfunction

  // Monitor: every DUT-presented event is matched against the expected queue.
  initial forever begin
    @(negedge clk);
    if (sda_dir) dir_seen = 1'b1;
    if (start_p) chk_ev(EV_START, 8'h00);
    if (stop_p) chk_ev(EV_STOP, 8'h00);
    if (rx_valid && !rxv_prev) chk_ev(EV_RX, rx_data);
    if (tx_ready) chk_ev(EV_TX, tx_data);
    rxv_prev = rx_valid;
  end

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_c();
    sda_m = 1'b1; wt(T); scl_m = 1'b1; wt(T); sda_m = 1'b0; wt(T); scl_m = 1'b0; wt(T);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; wt(T); scl_m = 1'b1; wt(T); sda_m = 1'b1; wt(T);
  endtask

  task automatic bit_c(input logic b, output logic s);
    sda_m = b; wt(T); scl_m = 1'b1; wt(T/2); s = sda_line; wt(T/2); scl_m = 1'b0; wt(T);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic a);
    logic s;
    for (int i = 7; i >= 0; i--) bit_c(d[i], s);
    bit_c(1'b1, s);
    a = !s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_c(1'b1, s);
      d[i] = s;
    end
    bit_c(!mack, s);
  endtask

  initial begin
    logic a, s;
    logic [7:0] d;
    wt(4);
    check("rst_state", dut.state_q, IDLE);
    check("rst_sda_dir", sda_dir, 0);
    check("rst_scl_dir", scl_dir, 0);
    check("rst_sda_o", sda_o, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_flags", {sel, rw, ovr, udr, start_p, stop_p, tx_ready}, 0);
    rst_n = 1'b1;
    wt(4);
    // write to own address, one data byte, consumer ready
    push(EV_START, 8'h00); start_c();
    write_byte(8'hA0, a);
    check("addr_ack", a, 1);
    check("sel_write", sel, 1);
    check("rw_write", rw, 0);
    push(EV_RX, 8'h3C); write_byte(8'h3C, a);
    check("data_ack", a, 1);
    check("rx_data_3c", rx_data, 8'h3C);
    push(EV_STOP, 8'h00); stop_c();
    check("sel_after_stop", sel, 0);
    check("state_after_stop", dut.state_q, IDLE);
    check("rx_valid_consumed", rx_valid, 0);
    // foreign address is ignored
    dir_seen = 1'b0;
    push(EV_START, 8'h00); start_c();
    write_byte(8'hA2, a);
    check("nack_other_addr", a, 0);
    check("sel_other_addr", sel, 0);
    check("state_wait_stop", dut.state_q, WAIT_STOP);
    write_byte(8'h55, a);
    check("ignore_data", a, 0);
    check("no_drive_other", dir_seen, 0);
    push(EV_STOP, 8'h00); stop_c();
    // read one byte, master NACKs
    tx_data = 8'h96; tx_valid = 1'b1;
    push(EV_START, 8'h00); start_c();
    push(EV_TX, 8'h96); write_byte(8'hA1, a);
    check("read_addr_ack", a, 1);
    check("rw_read", rw, 1);
    check("state_tx", dut.state_q, TX);
    read_byte(1'b0, d);
    check("tx_bits_96", d, 8'h96);
    check("state_after_nack", dut.state_q, WAIT_STOP);
    check("sda_released_nack", sda_dir, 0);
    dir_seen = 1'b0;
    read_byte(1'b0, d);
    check("bus_idle_after_nack", d, 8'hFF);
    check("no_drive_after_nack", dir_seen, 0);
    check("no_underrun", udr, 0);
    push(EV_STOP, 8'h00); stop_c();
    tx_valid = 1'b0;
    // overrun: consumer stalled across two bytes
    rx_ready = 1'b0;
    push(EV_START, 8'h00); start_c();
    write_byte(8'hA0, a);
    check("ovr_addr_ack", a, 1);
    push(EV_RX, 8'h11); write_byte(8'h11, a);
    check("ovr_first_ack", a, 1);
    write_byte(8'h22, a);
    check("overrun_nack", a, 0);
    check("ovr_set", ovr, 1);
    check("rx_keep_first", rx_data, 8'h11);
    check("rx_valid_held", rx_valid, 1);
    rx_ready = 1'b1;
    wt(2);
    check("rx_valid_clear", rx_valid, 0);
    push(EV_STOP, 8'h00); stop_c();
    // repeated START from write into read, two bytes read with master ACK then NACK
    tx_data = 8'h5A; tx_valid = 1'b1;
    push(EV_START, 8'h00); start_c();
    check("ovr_cleared_by_start", ovr, 0);
    write_byte(8'hA0, a);
    check("rs_addr_ack", a, 1);
    push(EV_RX, 8'h77); write_byte(8'h77, a);
    check("rs_data_ack", a, 1);
    push(EV_START, 8'h00); start_c();
    push(EV_TX, 8'h5A); write_byte(8'hA1, a);
    check("rs_read_ack", a, 1);
    check("rs_rw", rw, 1);
    check("rs_state_tx", dut.state_q, TX);
    tx_data = 8'hC3;
    push(EV_TX, 8'hC3);
    read_byte(1'b1, d);
    check("rs_tx_5a", d, 8'h5A);
    read_byte(1'b0, d);
    check("rs_tx_c3", d, 8'hC3);
    push(EV_STOP, 8'h00); stop_c();
    tx_valid = 1'b0;
    // underrun: no tx data offered
    push(EV_START, 8'h00); start_c();
    write_byte(8'hA1, a);
    check("udr_addr_ack", a, 1);
    check("udr_set", udr, 1);
    read_byte(1'b0, d);
    check("udr_sends_ff", d, 8'hFF);
    push(EV_STOP, 8'h00); stop_c();
    // disable mid-byte: bus released, no further pulses
    push(EV_START, 8'h00); start_c();
    write_byte(8'hA0, a);
    check("en_addr_ack", a, 1);
    for (int i = 0; i < 3; i++) bit_c(1'b0, s);
    en = 1'b0;
    wt(2);
    check("en_off_sda", sda_dir, 0);
    check("en_off_state", dut.state_q, IDLE);
    for (int i = 0; i < 5; i++) bit_c(1'b0, s);
    bit_c(1'b1, s);
    check("en_off_no_ack", s, 1);
    stop_c();
    en = 1'b1;
    wt(4);
    // reset while driving TX bit 3
    tx_data = 8'h00; tx_valid = 1'b1;
    push(EV_START, 8'h00); start_c();
    push(EV_TX, 8'h00); write_byte(8'hA1, a);
    check("rst_tx_addr_ack", a, 1);
    for (int i = 0; i < 4; i++) bit_c(1'b1, s);
    check("tx_bit3_driven", sda_dir, 1);
    rst_n = 1'b0;
    #1;
    check("rst_releases_sda", sda_dir, 0);
    wt(3);
    rst_n = 1'b1;
    scl_m = 1'b1; wt(T); scl_m = 1'b0; wt(T);
    dir_seen = 1'b0;
    write_byte(8'h00, a);
    check("no_resp_after_rst", a, 0);
    check("no_drive_after_rst", dir_seen, 0);
    check("sel_after_rst", sel, 0);
    tx_valid = 1'b0;
    push(EV_START, 8'h00); start_c();
    write_byte(8'hA0, a);
    check("ack_after_new_start", a, 1);
    push(EV_STOP, 8'h00); stop_c();
    wt(10);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
